// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with private HI/LO.
// One radix-2 step per cycle, then a sign-fixup cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dbz;
  logic [WIDTH-1:0] raw_a;
  logic [WIDTH-1:0] opnd;
  logic [2*WIDTH-1:0] acc;

  logic             sgn_op;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;

  logic [WIDTH:0]     psum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] acc_step;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Operand magnitudes and signs of the incoming request
  always_comb begin
    sgn_op = ~op[0];
    sa     = sgn_op & src_a[WIDTH-1];
    sb     = sgn_op & src_b[WIDTH-1];
    ma     = sa ? -src_a : src_a;
    mb     = sb ? -src_b : src_b;
  end

  // One shift-add or restoring-subtract step on the accumulator
  always_comb begin
    psum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
          + (acc[0] ? {1'b0, opnd} : '0);
    shl   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial = shl - {1'b0, opnd};
    if (!is_div)
      acc_step = {psum, acc[WIDTH-1:1]};
    else if (!trial[WIDTH])
      acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Sign correction and zero-divisor override for the final write
  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_r ? -acc[2*WIDTH-1:WIDTH]
                 : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (dbz) begin
      fix_hi = raw_a;
      fix_lo = '1;
    end else begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      raw_a       <= '0;
      opnd        <= '0;
      acc         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            is_div      <= op[1];
            neg_q       <= sa ^ sb;
            neg_r       <= sa;
            dbz         <= op[1] & (src_b == '0);
            raw_a       <= src_a;
            opnd        <= op[1] ? mb : ma;
            acc         <= {{WIDTH{1'b0}}, op[1] ? ma : mb};
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= dbz;
          hi          <= fix_hi;
          lo          <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit integer multiply/divide unit for the pipelined MIPS core, executing MULT, MULTU, DIV and DIVU into a private HI/LO register pair. The pipeline issues an operation with a start pulse and stalls on `busy`. The results later leave the core through MFHI/MFLO and stores, and the signed mult/div memory-check bench compares those stored values. The block is sequential: one radix-2 step per cycle, then one sign-fixup cycle.

## Interface
- `WIDTH`, 32, operand width. The HI and LO outputs are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request. It is accepted only in IDLE.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- `src_a`  in  WIDTH  multiplicand or dividend. Sampled with `start`.
- `src_b`  in  WIDTH  multiplier or divisor. Sampled with `start`.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO are updated.
- `div_by_zero`  out  1  sticky flag for the last operation: a DIV or DIVU with `src_b`==0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States:
  - IDLE: `start` -> CALC. The block latches `op`, the operand magnitudes (for signed ops), the result signs and the zero-divisor flag. The step counter is set to 0.
  - CALC: one step per cycle. After step WIDTH-1 -> FIX.
  - FIX: applies sign correction, writes HI/LO, pulses `done`, then -> IDLE.
- Multiply:
  - Shift-add on magnitudes into a 2·WIDTH accumulator.
  - Signed product sign = sign(a) XOR sign(b). FIX negates the accumulator (two's complement over 2·WIDTH) when that sign is negative.
  - HI = product[63:32], LO = product[31:0].
- Divide:
  - Restoring division on magnitudes. Quotient is truncated toward zero.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - LO = quotient, HI = remainder.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. There is no trap.
- Divide by zero:
  - Full latency runs as normal.
  - LO=0xFFFFFFFF, HI=`src_a` (the raw operand), `div_by_zero`=1.
  - `div_by_zero` clears when the next operation is accepted.
- `start` while `busy` is ignored. There is no queueing and the in-flight operands are unchanged.
- HI/LO hold their values until the next FIX cycle. MFHI/MFLO read them directly.
- Reset values: state IDLE, `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, counter 0.
- Reset asserted mid-operation aborts immediately. HI/LO return to 0 and no `done` is produced.
- For a `start` accepted during reset release, the reset behaviour takes precedence.

## Timing
- `start` is sampled at edge E0.
  - `busy`=1 from E0 through E0+WIDTH+1, i.e. 33 cycles for WIDTH=32.
  - CALC occupies edges E0+1 to E0+32.
  - FIX executes at edge E0+33. At that edge `busy` falls, `done` rises and HI/LO update in the same cycle.
  - `done` falls at E0+34.
- Back-to-back: `start` may be asserted in the cycle where `done`=1. The block is then in IDLE, so the request is accepted at E0+34.
- Throughput is one operation per 34 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Factorial chain: MULT -1×2, then the product ×3 … ×8. The bench reads LO after each `done`. Required LO sequence: -2, -6, -24, -120, -720, -5040, -40320. HI is always 0xFFFFFFFF.
- Signed divide:
  - -40320 / 2 -> LO=-20160, HI=0.
  - 7 / -2 -> LO=-3, HI=1.
  - -7 / 2 -> LO=-3, HI=-1.
  - In every case `done` is seen exactly 33 edges after the `start` edge.
- Unsigned and edge operands:
  - MULTU 0xFFFFFFFF×0xFFFFFFFF -> HI=0xFFFFFFFE, LO=1.
  - MULT 0x80000000×-1 -> HI=0, LO=0x80000000.
  - DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- Divide by zero: DIVU 3665/0 -> LO=0xFFFFFFFF, HI=3665, `div_by_zero`=1. A following MULT 5×-1 clears the flag and gives LO=-5.
- `start` pulsed at E0+10 during a busy operation -> ignored. The result matches the original operands and exactly one `done` pulse is produced.
- `rst` asserted at E0+15 -> `busy`, `done`, `hi`, `lo` all 0 immediately. After release, a new MULT 2×3 gives LO=6 with normal latency.
